// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S conversion scheduler.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    READ,
    UPDATE
  } a2d_state_e;

  localparam logic [2:0] CH_LFT_DEF   = 3'd0;
  localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
  localparam logic [2:0] CH_STEER_DEF = 3'd5;
  localparam logic [2:0] CH_BATT_DEF  = 3'd6;

  function automatic logic [15:0] cmd_word(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_gap_timer.sv
// Loadable down-counter timing the SS_n-high gap between command and read.
module a2d_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Flags the decrement that lands on zero, so a load of N yields N gap cycles.
  assign zero = (cnt_q <= W'(1));

endmodule

// File: rtl/a2d_conv_sched.sv
// Round-robin conversion scheduler driving the shared SPI master for the A2D.
module a2d_conv_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0] CH_LFT   = CH_LFT_DEF,
  parameter logic [2:0] CH_RGHT  = CH_RGHT_DEF,
  parameter logic [2:0] CH_STEER = CH_STEER_DEF,
  parameter logic [2:0] CH_BATT  = CH_BATT_DEF,
  parameter logic [3:0] GAP_CYC  = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_wt_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        ovr
);

  a2d_state_e  state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic        spi_wrt_q, spi_wrt_d;
  logic [15:0] wt_q, wt_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic [11:0] lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
  logic        tmr_load, tmr_dec, tmr_zero;
  logic [2:0]  chnl;
  logic [3:0]  unused_rd_hi;

  assign unused_rd_hi = spi_rd_data[15:12];

  a2d_gap_timer #(.W(4)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (GAP_CYC),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    case (rr_q)
      2'd0:    chnl = CH_LFT;
      2'd1:    chnl = CH_RGHT;
      2'd2:    chnl = CH_STEER;
      default: chnl = CH_BATT;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    spi_wrt_d = 1'b0;
    wt_d      = wt_q;
    busy_d    = busy_q;
    ovr_d     = ovr_q | (nxt && state_q != IDLE);
    lft_d     = lft_q;
    rght_d    = rght_q;
    steer_d   = steer_q;
    batt_d    = batt_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          spi_wrt_d = 1'b1;
          wt_d      = cmd_word(chnl);
          busy_d    = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: begin
        if (spi_done) begin
          tmr_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          spi_wrt_d = 1'b1;
          wt_d      = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (spi_done) begin
          case (rr_q)
            2'd0:    lft_d   = spi_rd_data[11:0];
            2'd1:    rght_d  = spi_rd_data[11:0];
            2'd2:    steer_d = spi_rd_data[11:0];
            default: batt_d  = spi_rd_data[11:0];
          endcase
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        rr_d    = rr_q + 2'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      spi_wrt_q <= 1'b0;
      wt_q      <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
      steer_q   <= '0;
      batt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      spi_wrt_q <= spi_wrt_d;
      wt_q      <= wt_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      steer_q   <= steer_d;
      batt_q    <= batt_d;
    end
  end

  assign spi_wrt     = spi_wrt_q;
  assign spi_wt_data = wt_q;
  assign busy        = busy_q;
  assign ovr         = ovr_q;
  assign lft_ld      = lft_q;
  assign rght_ld     = rght_q;
  assign steer_pot   = steer_q;
  assign batt        = batt_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched with a behavioural SPI master + ADC128S model.
module tb_a2d_conv_sched;

  localparam int unsigned GAP = 4;
  localparam int unsigned SPI_LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        f_done = 1'b0;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic        spi_wrt;
  logic [15:0] spi_wt_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        busy, ovr;

  // ADC model state
  logic [11:0] adc [8];
  logic [2:0]  m_ch = 3'd0, m_ch_prev = 3'd0;
  int unsigned m_cnt = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_rd = '0;
  int unsigned cyc = 0, done_cyc = 0, last_gap = 0;
  int unsigned wrt_cnt = 0, mdone_cnt = 0;
  logic [15:0] words[$];

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  assign spi_done    = m_done | f_done;
  assign spi_rd_data = f_done ? 16'hFFFF : m_rd;

  a2d_conv_sched #(.GAP_CYC(4'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nxt         (nxt),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data),
    .spi_wrt     (spi_wrt),
    .spi_wt_data (spi_wt_data),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .steer_pot   (steer_pot),
    .batt        (batt),
    .busy        (busy),
    .ovr         (ovr)
  );

  always #5 clk = ~clk;

  // SPI master/ADC: each transaction returns the channel latched by the previous one.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    m_done <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done    <= 1'b1;
        m_rd      <= {4'hA, adc[m_ch_prev]};
        done_cyc  <= cyc;
        mdone_cnt <= mdone_cnt + 1;
      end
    end
    if (spi_wrt) begin
      m_cnt     <= SPI_LEN;
      m_ch_prev <= m_ch;
      m_ch      <= spi_wt_data[13:11];
      last_gap  <= cyc - done_cyc - 1;
      wrt_cnt   <= wrt_cnt + 1;
      words.push_back(spi_wt_data);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 16'(k < 200), 16'd1);
    @(negedge clk);
  endtask

  task automatic conv(input string tag);
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    wait_idle(tag);
  endtask

  task automatic wait_wrt(input int unsigned target, input string tag);
    int unsigned k = 0;
    while (wrt_cnt < target && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk(tag, 16'(k < 100), 16'd1);
  endtask

  initial begin
    int unsigned base;
    foreach (adc[i]) adc[i] = 12'h123;
    adc[0] = 12'd330; adc[4] = 12'd320; adc[5] = 12'h800; adc[6] = 12'hC00;

    // Reset state
    #1;
    chk("rst_lft", 16'(lft_ld), 16'h0);
    chk("rst_wrt", 16'(spi_wrt), 16'h0);
    chk("rst_wt",  spi_wt_data, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_ovr", 16'(ovr), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: one full round
    conv("t1_lft_to");
    chk("t1_cmd0", words[$-1], 16'h0000);
    chk("t1_rd0", words[$], 16'h0000);
    chk("t1_gap", 16'(last_gap), 16'(GAP));
    conv("t1_rght_to");
    chk("t1_cmd1", words[$-1], 16'h2000);
    conv("t1_steer_to");
    chk("t1_cmd2", words[$-1], 16'h2800);
    conv("t1_batt_to");
    chk("t1_cmd3", words[$-1], 16'h3000);
    chk("t1_lft", 16'(lft_ld), 16'd330);
    chk("t1_rght", 16'(rght_ld), 16'd320);
    chk("t1_steer", 16'(steer_pot), 16'h0800);
    chk("t1_batt", 16'(batt), 16'h0C00);
    chk("t1_ovr", 16'(ovr), 16'h0);
    chk("t1_wrts", 16'(wrt_cnt), 16'd8);

    // 2: wrap to left; only lft_ld moves
    adc[0] = 12'd100;
    conv("t2_to");
    chk("t2_cmd", words[$-1], 16'h0000);
    chk("t2_lft", 16'(lft_ld), 16'd100);
    chk("t2_rght", 16'(rght_ld), 16'd320);
    chk("t2_steer", 16'(steer_pot), 16'h0800);
    chk("t2_batt", 16'(batt), 16'h0C00);

    // 3: nxt during CMD and during READ (right channel)
    adc[4] = 12'h155;
    base = wrt_cnt;
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    repeat (2) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    chk("t3_ovr_cmd", 16'(ovr), 16'h1);
    wait_wrt(base + 2, "t3_rd_to");
    repeat (2) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    wait_idle("t3_to");
    chk("t3_wrts", 16'(wrt_cnt - base), 16'd2);
    chk("t3_cmd", words[$-1], 16'h2000);
    chk("t3_rght", 16'(rght_ld), 16'h0155);
    chk("t3_ovr", 16'(ovr), 16'h1);

    // 4: spurious spi_done in IDLE, then in GAP (steer channel)
    base = wrt_cnt;
    @(negedge clk) f_done = 1'b1;
    @(negedge clk) f_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_idle_wrt", 16'(wrt_cnt - base), 16'd0);
    chk("t4_idle_busy", 16'(busy), 16'h0);
    chk("t4_idle_lft", 16'(lft_ld), 16'd100);
    chk("t4_idle_rght", 16'(rght_ld), 16'h0155);
    adc[5] = 12'h3FF;
    base = mdone_cnt;
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    for (int i = 0; i < 40 && mdone_cnt == base; i++) @(posedge clk);
    chk("t4_cmd_done_seen", 16'(mdone_cnt - base), 16'd1);
    repeat (2) @(negedge clk);
    f_done = 1'b1;
    @(negedge clk) f_done = 1'b0;
    wait_idle("t4_to");
    chk("t4_cmd", words[$-1], 16'h2800);
    chk("t4_gap", 16'(last_gap), 16'(GAP));
    chk("t4_steer", 16'(steer_pot), 16'h03FF);
    chk("t4_batt", 16'(batt), 16'h0C00);
    chk("t4_ovr", 16'(ovr), 16'h1);

    // 5: reset during READ (battery channel)
    base = wrt_cnt;
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    wait_wrt(base + 2, "t5_rd_to");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_lft", 16'(lft_ld), 16'h0);
    chk("t5_rght", 16'(rght_ld), 16'h0);
    chk("t5_steer", 16'(steer_pot), 16'h0);
    chk("t5_batt", 16'(batt), 16'h0);
    chk("t5_busy", 16'(busy), 16'h0);
    chk("t5_ovr", 16'(ovr), 16'h0);
    chk("t5_wt", spi_wt_data, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    base = mdone_cnt;
    for (int i = 0; i < 40 && mdone_cnt == base; i++) @(posedge clk);
    chk("t5_late_done_seen", 16'(mdone_cnt - base), 16'd1);
    repeat (2) @(negedge clk);
    chk("t5_late_lft", 16'(lft_ld), 16'h0);
    chk("t5_late_batt", 16'(batt), 16'h0);
    chk("t5_late_busy", 16'(busy), 16'h0);
    conv("t5_to");
    chk("t5_cmd", words[$-1], 16'h0000);
    chk("t5_lft_new", 16'(lft_ld), 16'd100);
    chk("t5_batt_hold", 16'(batt), 16'h0);
    chk("t5_ovr_new", 16'(ovr), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
